// File: rtl/axil_pkg.sv
// Shared AXI-lite definitions for read-channel slaves.
// Provides the RRESP encodings and the packed R-beat payload (resp + data)
// carried through response FIFOs.
package axil_pkg;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [1:0] RRESP_DECERR = 2'b11;

    localparam int unsigned RDATA_W = 32;

    // One R-channel beat as stored in a response FIFO.
    typedef struct packed {
        logic [1:0]         resp;
        logic [RDATA_W-1:0] data;
    } axil_rbeat_t;

endpackage

// File: rtl/axil_rsp_fifo.sv
// First-word-fall-through response FIFO.
// Ports: clk/rst_n (sync active-low, pointers only), push/push_data write
// side, pop read side, head = current front entry (combinational),
// empty/full status flags.
module axil_rsp_fifo #(
    parameter int unsigned DATA_LEN = 34,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [DATA_LEN-1:0] push_data,
    input  logic                pop,
    output logic [DATA_LEN-1:0] head,
    output logic                empty,
    output logic                full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [AW:0]         wr_ptr;
    logic [AW:0]         rd_ptr;
    logic [DATA_LEN-1:0] store [DEPTH];

    // Pointer update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) store[wr_ptr[AW-1:0]] <= push_data;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = store[rd_ptr[AW-1:0]];

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/isram_axil_rd.sv
// Read-only AXI-lite instruction memory slave feeding the fetch unit.
// Every accepted AR is answered by exactly one in-order R beat after LATENCY
// cycles; up to OUTSTANDING requests may be in flight. Out-of-range reads
// return DECERR with zero data. A backdoor load port fills the array.
// Ports: clk, rst_n (sync active-low); AR channel arvalid/arready/araddr;
// R channel rvalid/rready/rresp/rdata; backdoor load_en/load_addr/load_data.
module isram_axil_rd
    import axil_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arvalid,
    output logic        arready,
    input  logic [63:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [1:0]  rresp,
    output logic [31:0] rdata,
    input  logic        load_en,
    input  logic [63:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = $clog2(OUTSTANDING) + 1;
    localparam logic [63:0] SPAN_BYTES = 64'(DEPTH_WORDS) << 2;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [31:0] mem [DEPTH_WORDS];

    logic [CNT_W-1:0] inflight;
    logic             ar_hs;
    logic             r_hs;

    logic [63:0]      ar_off;
    logic             dec_err;
    logic [IDX_W-1:0] dec_idx;

    logic [63:0]      ld_off;
    logic             ld_hit;
    logic [IDX_W-1:0] ld_idx;

    logic             fin_valid;
    logic             fin_err;
    logic [IDX_W-1:0] fin_idx;
    axil_rbeat_t      fin_beat;

    axil_rbeat_t      fifo_head;
    logic             fifo_empty;
    logic             fifo_full;

    assign arready = rst_n & (inflight != CNT_MAX);
    assign ar_hs   = arvalid & arready;
    assign r_hs    = rvalid & rready;

    // Accepted-but-unconsumed request count; bounds FIFO occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight <= '0;
        end else if (ar_hs && !r_hs) begin
            inflight <= inflight + CNT_ONE;
        end else if (r_hs && !ar_hs) begin
            inflight <= inflight - CNT_ONE;
        end
    end

    // Address decode; a borrow past zero or an offset beyond the array is an error.
    assign ar_off  = araddr - BASE_ADDR;
    assign dec_err = (araddr < BASE_ADDR) || (ar_off >= SPAN_BYTES);
    assign dec_idx = ar_off[IDX_W+1:2];

    assign ld_off = load_addr - BASE_ADDR;
    assign ld_hit = (load_addr >= BASE_ADDR) && (ld_off < SPAN_BYTES);
    assign ld_idx = ld_off[IDX_W+1:2];

    // Backdoor write; array contents survive reset.
    always_ff @(posedge clk) begin
        if (load_en && ld_hit) mem[ld_idx] <= load_data;
    end

    // Fixed-latency pipeline of LATENCY-1 stages; never stalls because the
    // inflight bound guarantees FIFO room for every stage entry.
    if (LATENCY == 1) begin : g_lat1
        assign fin_valid = ar_hs;
        assign fin_err   = dec_err;
        assign fin_idx   = dec_idx;
    end else begin : g_pipe
        localparam int unsigned NS = LATENCY - 1;

        logic [NS-1:0]    v_q;
        logic [NS-1:0]    e_q;
        logic [IDX_W-1:0] i_q [NS];

        always_ff @(posedge clk) begin
            if (!rst_n) v_q <= '0;
            else        v_q <= NS'({v_q, ar_hs});
        end

        always_ff @(posedge clk) begin
            e_q    <= NS'({e_q, dec_err});
            i_q[0] <= dec_idx;
            for (int s = 1; s < int'(NS); s++) i_q[s] <= i_q[s-1];
        end

        assign fin_valid = v_q[NS-1];
        assign fin_err   = e_q[NS-1];
        assign fin_idx   = i_q[NS-1];
    end

    // Final-stage array read happens before this edge's backdoor write.
    always_comb begin
        fin_beat.resp = RRESP_OKAY;
        fin_beat.data = '0;
        if (fin_err) begin
            fin_beat.resp = RRESP_DECERR;
        end else begin
            fin_beat.data = mem[fin_idx];
        end
    end

    axil_rsp_fifo #(
        .DATA_LEN ($bits(axil_rbeat_t)),
        .DEPTH    (OUTSTANDING)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fin_valid),
        .push_data (fin_beat),
        .pop       (r_hs),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    a_push_room: assert property (@(posedge clk) disable iff (!rst_n) !(fin_valid && fifo_full));

    // R outputs are forced to zero whenever no beat is presented.
    assign rvalid = rst_n & ~fifo_empty;
    assign rresp  = rvalid ? fifo_head.resp : 2'b00;
    assign rdata  = rvalid ? fifo_head.data : 32'h0;

endmodule
